// File: rtl/gecko_load_response_pkg.sv
// Shared types for the load-response path.
// Contents: register/status types, the load op encoding, the command and
// result payload structs, and the load alignment helper.
package gecko_load_response_pkg;

    localparam int unsigned XLEN         = 32;
    localparam int unsigned REG_ADDR_W   = 5;
    localparam int unsigned REG_STATUS_W = 3;

    typedef logic [REG_ADDR_W-1:0]   rv32_reg_addr_t;
    typedef logic [REG_STATUS_W-1:0] gecko_reg_status_t;

    // funct3 encodings of the RV32I loads
    typedef enum logic [2:0] {
        GECKO_LOAD_LB  = 3'b000,
        GECKO_LOAD_LH  = 3'b001,
        GECKO_LOAD_LW  = 3'b010,
        GECKO_LOAD_LBU = 3'b100,
        GECKO_LOAD_LHU = 3'b101
    } gecko_load_op_t;

    // Metadata captured when the memory read is issued
    typedef struct packed {
        rv32_reg_addr_t    addr;
        gecko_reg_status_t reg_status;
        gecko_load_op_t    op;
        logic [1:0]        offset;
    } gecko_load_command_t;

    // Register result handed to writeback
    typedef struct packed {
        logic [XLEN-1:0]   value;
        rv32_reg_addr_t    addr;
        gecko_reg_status_t reg_status;
        logic              speculative;
    } gecko_operation_t;

    // Select and extend the addressed byte/half of a word; unknown ops act as LW
    function automatic logic [XLEN-1:0] gecko_align_load(
        input gecko_load_op_t  op,
        input logic [1:0]      offset,
        input logic [XLEN-1:0] data
    );
        logic [7:0]      w_byte;
        logic [15:0]     w_half;
        logic [XLEN-1:0] w_result;
        w_byte = 8'(data >> {offset, 3'b000});
        w_half = offset[1] ? data[31:16] : data[15:0];
        case (op)
            GECKO_LOAD_LB:  w_result = {{24{w_byte[7]}}, w_byte};
            GECKO_LOAD_LBU: w_result = {24'h0, w_byte};
            GECKO_LOAD_LH:  w_result = {{16{w_half[15]}}, w_half};
            GECKO_LOAD_LHU: w_result = {16'h0, w_half};
            default:        w_result = data;
        endcase
        return w_result;
    endfunction

endpackage

// File: rtl/gecko_load_response_if.sv
// Valid/ready stream carrying a payload of type T.
// master drives valid/payload and samples ready; slave the reverse.
interface gecko_load_response_if #(
    parameter type T = logic
);
    logic valid;
    logic ready;
    T     payload;

    modport master (output valid, output payload, input ready);
    modport slave  (input valid, input payload, output ready);
endinterface

// File: rtl/gecko_load_metadata_fifo.sv
// DEPTH-entry synchronous FIFO holding outstanding-load metadata.
// Ports: clk, rst (sync, active-high); i_push/i_wdata write side;
// i_pop/o_rdata_c read side (head visible combinationally);
// o_full_c/o_empty_c flags decoded from the count register; o_count.
module gecko_load_metadata_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_wdata,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_rdata_c,
    output logic                       o_full_c,
    output logic                       o_empty_c,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full_c  = (r_count == CNT_W'(DEPTH));
    assign o_empty_c = (r_count == '0);
    assign o_rdata_c = r_mem[r_rd_ptr];
    assign o_count   = r_count;

    // Guard against overflow/underflow regardless of the caller
    assign w_push = i_push && !o_full_c;
    assign w_pop  = i_pop && !o_empty_c;

    // Entry storage; contents need no reset since the count gates reads
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/gecko_load_response.sv
// Pairs in-order memory read data with queued load metadata and produces an
// aligned, extended register result for writeback.
// Ports: clk, rst (sync, active-high); i_load_command (metadata in);
// i_mem_response (32-bit read data in); o_load_result (gecko_operation_t out,
// registered); o_outstanding_count (queued entries).
module gecko_load_response
    import gecko_load_response_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    gecko_load_response_if.slave       i_load_command,
    gecko_load_response_if.slave       i_mem_response,
    gecko_load_response_if.master      o_load_result,
    output logic [$clog2(DEPTH+1)-1:0] o_outstanding_count
);
    localparam int unsigned CMD_W = $bits(gecko_load_command_t);

    logic                w_push;
    logic                w_pop;
    logic                w_full;
    logic                w_empty;
    logic                w_resp_ready;
    logic [CMD_W-1:0]    w_head_bits;
    gecko_load_command_t w_head;
    gecko_operation_t    w_next_payload;
    logic                r_valid;
    gecko_operation_t    r_payload;

    // Command ready depends only on the count register, never on this cycle's pop
    assign i_load_command.ready = !w_full;
    assign w_push               = i_load_command.valid && !w_full;

    // A response needs a queued entry and room in the output stage
    assign w_resp_ready         = !w_empty && (!r_valid || o_load_result.ready);
    assign i_mem_response.ready = w_resp_ready;
    assign w_pop                = i_mem_response.valid && w_resp_ready;

    gecko_load_metadata_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (CMD_W)
    ) u_metadata_fifo (
        .clk       (clk),
        .rst       (rst),
        .i_push    (w_push),
        .i_wdata   (i_load_command.payload),
        .i_pop     (w_pop),
        .o_rdata_c (w_head_bits),
        .o_full_c  (w_full),
        .o_empty_c (w_empty),
        .o_count   (o_outstanding_count)
    );

    assign w_head = gecko_load_command_t'(w_head_bits);

    // Result built from the head entry and the arriving data
    always_comb begin
        w_next_payload            = '0;
        w_next_payload.value      = gecko_align_load(w_head.op, w_head.offset,
                                                     i_mem_response.payload);
        w_next_payload.addr       = w_head.addr;
        w_next_payload.reg_status = w_head.reg_status;
    end

    // Single output register; holds until accepted
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid   <= 1'b0;
            r_payload <= '0;
        end else if (w_pop) begin
            r_valid   <= 1'b1;
            r_payload <= w_next_payload;
        end else if (o_load_result.ready) begin
            r_valid   <= 1'b0;
        end
    end

    assign o_load_result.valid   = r_valid;
    assign o_load_result.payload = r_payload;

endmodule

// File: tb/tb_gecko_load_response.sv
module tb_gecko_load_response;
    import gecko_load_response_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned CNT_W = $clog2(DEPTH+1);

    logic clk = 1'b0;
    logic rst;
    logic [CNT_W-1:0] count;

    always #5 clk = ~clk;

    gecko_load_response_if #(.T(gecko_load_command_t)) cmd_if ();
    gecko_load_response_if #(.T(logic [31:0]))         resp_if ();
    gecko_load_response_if #(.T(gecko_operation_t))    res_if ();

    gecko_load_response #(.DEPTH(DEPTH)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .i_load_command      (cmd_if),
        .i_mem_response      (resp_if),
        .o_load_result       (res_if),
        .o_outstanding_count (count)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    gecko_load_command_t cmd_q[$];
    gecko_operation_t    exp_q[$];

    function automatic gecko_load_command_t mk_cmd(input logic [4:0] a, input logic [2:0] s,
                                                   input logic [2:0] op, input logic [1:0] off);
        return gecko_load_command_t'({a, s, op, off});
    endfunction

    // Reference alignment written directly from the load definitions
    function automatic logic [31:0] model_align(input logic [2:0] op, input logic [1:0] off,
                                                input logic [31:0] d);
        logic [7:0]  b;
        logic [15:0] h;
        case (off)
            2'd0:    b = d[7:0];
            2'd1:    b = d[15:8];
            2'd2:    b = d[23:16];
            default: b = d[31:24];
        endcase
        h = (off >= 2'd2) ? d[31:16] : d[15:0];
        case (op)
            3'b000:  return {{24{b[7]}}, b};
            3'b100:  return {24'h0, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b101:  return {16'h0, h};
            default: return d;
        endcase
    endfunction

    // Scoreboard: commands queued on accept, expectations on response accept, compared on result accept
    always @(negedge clk) begin
        if (!rst) begin
            if (res_if.valid && res_if.ready) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_unexpected_result: got %h, none expected", res_if.payload);
                end else begin
                    gecko_operation_t e;
                    e = exp_q.pop_front();
                    if (res_if.payload !== e) begin
                        n_fail++;
                        $display("FAIL sb_result: got %h expected %h", res_if.payload, e);
                    end
                end
            end
            if (resp_if.valid && resp_if.ready) begin
                if (cmd_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL sb_response_without_command: data %h", resp_if.payload);
                end else begin
                    gecko_load_command_t c;
                    gecko_operation_t    e;
                    c = cmd_q.pop_front();
                    e = '0;
                    e.value      = model_align(c.op, c.offset, resp_if.payload);
                    e.addr       = c.addr;
                    e.reg_status = c.reg_status;
                    exp_q.push_back(e);
                end
            end
            if (cmd_if.valid && cmd_if.ready) begin
                cmd_q.push_back(cmd_if.payload);
            end
        end
    end

    task automatic send_cmd(input gecko_load_command_t c);
        bit ok = 0;
        cmd_if.payload = c;
        cmd_if.valid   = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (cmd_if.ready) begin ok = 1; break; end
        end
        if (!ok) begin
            n_cmp++; n_fail++;
            $display("FAIL send_cmd_timeout: ready %b required 1", cmd_if.ready);
        end
        @(posedge clk); #1;
        cmd_if.valid = 1'b0;
    endtask

    task automatic send_resp(input logic [31:0] d);
        bit ok = 0;
        resp_if.payload = d;
        resp_if.valid   = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (resp_if.ready) begin ok = 1; break; end
        end
        if (!ok) begin
            n_cmp++; n_fail++;
            $display("FAIL send_resp_timeout: ready %b required 1", resp_if.ready);
        end
        @(posedge clk); #1;
        resp_if.valid = 1'b0;
    endtask

    task automatic wait_result(output gecko_operation_t p, output bit ok);
        ok = 0;
        p  = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (res_if.valid && res_if.ready) begin p = res_if.payload; ok = 1; break; end
        end
        if (!ok) begin
            n_cmp++; n_fail++;
            $display("FAIL wait_result_timeout: valid %b required 1", res_if.valid);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cmd_if.valid = 1'b0;  cmd_if.payload = '0;
        resp_if.valid = 1'b0; resp_if.payload = '0;
        res_if.ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (res_if.valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b required 0", res_if.valid); end
        n_cmp++; if (res_if.payload !== '0) begin n_fail++; $display("FAIL reset_payload: got %h required 0", res_if.payload); end
        n_cmp++; if (count !== '0) begin n_fail++; $display("FAIL reset_count: got %0d required 0", count); end
        n_cmp++; if (cmd_if.ready !== 1'b1) begin n_fail++; $display("FAIL reset_cmd_ready: got %b required 1", cmd_if.ready); end
        n_cmp++; if (resp_if.ready !== 1'b0) begin n_fail++; $display("FAIL reset_resp_ready: got %b required 0", resp_if.ready); end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_alignment();
        logic [2:0]  t_op  [10] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b001,
                                    3'b101, 3'b010, 3'b011, 3'b111, 3'b000};
        logic [1:0]  t_off [10] = '{2'd3, 2'd3, 2'd2, 2'd0, 2'd1, 2'd3, 2'd3, 2'd1, 2'd2, 2'd1};
        logic [31:0] t_d   [10] = '{32'h80FF_1234, 32'h80FF_1234, 32'h8001_7FFF, 32'h8001_7FFF,
                                    32'h1234_8765, 32'h1234_8765, 32'hDEAD_BEEF, 32'hCAFE_F00D,
                                    32'h8000_0080, 32'h0000_8000};
        logic [31:0] t_exp [10] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8001, 32'h0000_7FFF,
                                    32'hFFFF_8765, 32'h0000_1234, 32'hDEAD_BEEF, 32'hCAFE_F00D,
                                    32'h8000_0080, 32'hFFFF_FF80};
        gecko_operation_t p;
        bit ok;
        res_if.ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            send_cmd(mk_cmd(5'(i + 3), 3'(i), t_op[i], t_off[i]));
            send_resp(t_d[i]);
            wait_result(p, ok);
            if (ok) begin
                n_cmp++; if (p.value !== t_exp[i]) begin n_fail++; $display("FAIL align_value[%0d]: got %h required %h", i, p.value, t_exp[i]); end
                n_cmp++; if (p.addr !== 5'(i + 3)) begin n_fail++; $display("FAIL align_addr[%0d]: got %0d required %0d", i, p.addr, i + 3); end
                n_cmp++; if (p.reg_status !== 3'(i)) begin n_fail++; $display("FAIL align_status[%0d]: got %0d required %0d", i, p.reg_status, i); end
            end
        end
    endtask

    task automatic test_full();
        res_if.ready = 1'b1;
        for (int i = 0; i < 4; i++) send_cmd(mk_cmd(5'(20 + i), 3'(i), 3'b010, 2'd0));
        @(negedge clk);
        n_cmp++; if (count !== CNT_W'(4)) begin n_fail++; $display("FAIL full_count: got %0d required 4", count); end
        n_cmp++; if (cmd_if.ready !== 1'b0) begin n_fail++; $display("FAIL full_cmd_ready: got %b required 0", cmd_if.ready); end
        @(posedge clk); #1;
        cmd_if.payload = mk_cmd(5'd30, 3'd7, 3'b010, 2'd0);
        cmd_if.valid = 1'b1;
        resp_if.payload = 32'h0BAD_F00D;
        resp_if.valid = 1'b1;
        @(negedge clk);
        n_cmp++; if (count !== CNT_W'(4)) begin n_fail++; $display("FAIL full_pop_count: got %0d required 4", count); end
        n_cmp++; if (cmd_if.ready !== 1'b0) begin n_fail++; $display("FAIL full_pop_cmd_ready: got %b required 0", cmd_if.ready); end
        n_cmp++; if (resp_if.ready !== 1'b1) begin n_fail++; $display("FAIL full_pop_resp_ready: got %b required 1", resp_if.ready); end
        @(posedge clk); #1;
        cmd_if.valid = 1'b0;
        resp_if.valid = 1'b0;
        @(negedge clk);
        n_cmp++; if (count !== CNT_W'(3)) begin n_fail++; $display("FAIL after_pop_count: got %0d required 3", count); end
        n_cmp++; if (cmd_if.ready !== 1'b1) begin n_fail++; $display("FAIL after_pop_cmd_ready: got %b required 1", cmd_if.ready); end
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) send_resp(32'h1000_0000 + 32'(i));
        @(negedge clk);
        n_cmp++; if (count !== '0) begin n_fail++; $display("FAIL drained_count: got %0d required 0", count); end
        @(posedge clk); #1;
    endtask

    task automatic test_empty_stall();
        res_if.ready = 1'b1;
        resp_if.payload = 32'h0000_00A5;
        resp_if.valid = 1'b1;
        @(negedge clk);
        n_cmp++; if (resp_if.ready !== 1'b0) begin n_fail++; $display("FAIL empty_resp_ready: got %b required 0", resp_if.ready); end
        @(posedge clk); #1;
        cmd_if.payload = mk_cmd(5'd9, 3'd4, 3'b100, 2'd0);
        cmd_if.valid = 1'b1;
        @(negedge clk);
        n_cmp++; if (resp_if.ready !== 1'b0) begin n_fail++; $display("FAIL same_cycle_resp_ready: got %b required 0", resp_if.ready); end
        @(posedge clk); #1;
        cmd_if.valid = 1'b0;
        @(negedge clk);
        n_cmp++; if (resp_if.ready !== 1'b1) begin n_fail++; $display("FAIL next_cycle_resp_ready: got %b required 1", resp_if.ready); end
        n_cmp++; if (res_if.valid !== 1'b0) begin n_fail++; $display("FAIL early_valid: got %b required 0", res_if.valid); end
        @(posedge clk); #1;
        resp_if.valid = 1'b0;
        @(negedge clk);
        n_cmp++; if (res_if.valid !== 1'b1) begin n_fail++; $display("FAIL latency_valid: got %b required 1", res_if.valid); end
        n_cmp++; if (res_if.payload.value !== 32'h0000_00A5) begin n_fail++; $display("FAIL latency_value: got %h required 000000a5", res_if.payload.value); end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        res_if.ready = 1'b0;
        send_cmd(mk_cmd(5'd11, 3'd1, 3'b010, 2'd0));
        send_cmd(mk_cmd(5'd12, 3'd2, 3'b010, 2'd0));
        resp_if.payload = 32'h1111_1111;
        resp_if.valid = 1'b1;
        @(negedge clk);
        n_cmp++; if (resp_if.ready !== 1'b1) begin n_fail++; $display("FAIL bp_first_ready: got %b required 1", resp_if.ready); end
        @(posedge clk); #1;
        resp_if.payload = 32'h2222_2222;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++; if (res_if.valid !== 1'b1) begin n_fail++; $display("FAIL bp_hold_valid[%0d]: got %b required 1", i, res_if.valid); end
            n_cmp++; if (res_if.payload.value !== 32'h1111_1111) begin n_fail++; $display("FAIL bp_stable[%0d]: got %h required 11111111", i, res_if.payload.value); end
            n_cmp++; if (resp_if.ready !== 1'b0) begin n_fail++; $display("FAIL bp_resp_stall[%0d]: got %b required 0", i, resp_if.ready); end
            n_cmp++; if (count !== CNT_W'(1)) begin n_fail++; $display("FAIL bp_count[%0d]: got %0d required 1", i, count); end
            @(posedge clk); #1;
        end
        res_if.ready = 1'b1;
        @(negedge clk);
        n_cmp++; if (resp_if.ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready: got %b required 1", resp_if.ready); end
        @(posedge clk); #1;
        resp_if.valid = 1'b0;
        @(negedge clk);
        n_cmp++; if (res_if.payload.value !== 32'h2222_2222) begin n_fail++; $display("FAIL bp_second_value: got %h required 22222222", res_if.payload.value); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        logic [31:0] sd [8];
        int ci = 4, ri = 0, nres = 0, first = -1, last = -1, cyc = 0;
        bit c_hs, r_hs;
        res_if.ready = 1'b1;
        for (int i = 0; i < 8; i++) sd[i] = $urandom;
        for (int i = 0; i < 4; i++) send_cmd(mk_cmd(5'(i + 1), 3'(i), 3'(i % 6), 2'(i)));
        cmd_if.payload = mk_cmd(5'(ci + 1), 3'(ci), 3'(ci % 6), 2'(ci));
        cmd_if.valid = 1'b1;
        resp_if.payload = sd[0];
        resp_if.valid = 1'b1;
        while (ri < 8 && cyc < 60) begin
            @(negedge clk);
            c_hs = cmd_if.valid && cmd_if.ready;
            r_hs = resp_if.valid && resp_if.ready;
            if (res_if.valid) begin if (first < 0) first = cyc; last = cyc; nres++; end
            @(posedge clk); #1;
            cyc++;
            if (c_hs) begin
                ci++;
                if (ci < 8) cmd_if.payload = mk_cmd(5'(ci + 1), 3'(ci), 3'(ci % 6), 2'(ci));
                else cmd_if.valid = 1'b0;
            end
            if (r_hs) begin
                ri++;
                if (ri < 8) resp_if.payload = sd[ri];
                else resp_if.valid = 1'b0;
            end
        end
        cmd_if.valid = 1'b0;
        resp_if.valid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (res_if.valid) begin if (first < 0) first = cyc; last = cyc; nres++; end
            @(posedge clk); #1;
            cyc++;
        end
        n_cmp++; if (ri !== 8) begin n_fail++; $display("FAIL b2b_responses: got %0d required 8", ri); end
        n_cmp++; if (nres !== 8) begin n_fail++; $display("FAIL b2b_results: got %0d required 8", nres); end
        n_cmp++; if (last - first !== 7) begin n_fail++; $display("FAIL b2b_span: got %0d required 7", last - first); end
        n_cmp++; if (exp_q.size() !== 0) begin n_fail++; $display("FAIL b2b_leftover: got %0d required 0", exp_q.size()); end
    endtask

    task automatic test_reset_mid();
        res_if.ready = 1'b0;
        for (int i = 0; i < 4; i++) send_cmd(mk_cmd(5'(i + 16), 3'(i), 3'b010, 2'd0));
        send_resp(32'h5555_AAAA);
        resp_if.payload = 32'h6666_BBBB;
        resp_if.valid = 1'b1;
        @(negedge clk);
        n_cmp++; if (count !== CNT_W'(3)) begin n_fail++; $display("FAIL pre_rst_count: got %0d required 3", count); end
        n_cmp++; if (res_if.valid !== 1'b1) begin n_fail++; $display("FAIL pre_rst_valid: got %b required 1", res_if.valid); end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        cmd_q.delete();
        exp_q.delete();
        @(negedge clk);
        n_cmp++; if (res_if.valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_valid: got %b required 0", res_if.valid); end
        n_cmp++; if (count !== '0) begin n_fail++; $display("FAIL rst_mid_count: got %0d required 0", count); end
        n_cmp++; if (cmd_if.ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_cmd_ready: got %b required 1", cmd_if.ready); end
        n_cmp++; if (resp_if.ready !== 1'b0) begin n_fail++; $display("FAIL rst_mid_resp_ready: got %b required 0", resp_if.ready); end
        @(posedge clk); #1;
        @(negedge clk);
        n_cmp++; if (resp_if.ready !== 1'b0) begin n_fail++; $display("FAIL rst_mid_stall: got %b required 0", resp_if.ready); end
        @(posedge clk); #1;
        resp_if.valid = 1'b0;
        res_if.ready = 1'b1;
    endtask

    initial begin
        test_reset();
        test_alignment();
        test_full();
        test_empty_stall();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
